// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner: sync, prescaled debounce and edge strobes
// for the irrigation sensor and switch lines.
module sensor_input_conditioner #(
  parameter int                 WIDTH          = 8,
  parameter int                 PRESCALE       = 1000,
  parameter int                 STABLE_SAMPLES = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE    = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_inputs,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rising,
  output logic [WIDTH-1:0] falling,
  output logic             any_change,
  output logic             sample_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0]         sync_q1;
  logic [WIDTH-1:0]         sync_q2;
  logic [PW-1:0]            pre_cnt;
  logic                     tick_now;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  logic [WIDTH-1:0]         deb_d;
  logic [WIDTH-1:0]         rise_d;
  logic [WIDTH-1:0]         fall_d;

  // Tick is decided from the prescaler so the filter acts on the
  // same edge that raises sample_tick.
  assign tick_now = (pre_cnt == P_LAST);

  // Two-flop synchroniser, clocked every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= RESET_VALUE;
      sync_q2 <= RESET_VALUE;
    end else begin
      sync_q1 <= raw_inputs;
      sync_q2 <= sync_q1;
    end
  end

  // Free-running prescaler with registered tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      pre_cnt     <= tick_now ? '0 : pre_cnt + PW'(1);
      sample_tick <= tick_now;
    end
  end

  // Per-bit mismatch counting and acceptance of a new level.
  always_comb begin
    deb_d  = debounced;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    if (tick_now) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sync_q2[b] == debounced[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == C_LAST) begin
          deb_d[b]  = sync_q2[b];
          rise_d[b] = sync_q2[b];
          fall_d[b] = ~sync_q2[b];
          cnt_d[b]  = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  // Filter state and one-cycle strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      debounced  <= RESET_VALUE;
      rising     <= '0;
      falling    <= '0;
      any_change <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      debounced  <= deb_d;
      rising     <= rise_d;
      falling    <= fall_d;
      any_change <= (|rise_d) | (|fall_d);
    end
  end

endmodule
